hci_hwpe_wide_splitter: RTL and testbench

- Splits one wide HWPE request of NB_IN_CHAN words onto NB_OUT_CHAN word-interleaved TCDM banks.
- Unlike the single-grant interconnect, grants are tracked per word, so banks may grant in different cycles. Words already granted are never re-issued.
- Read data is collected into a response buffer and returned as one wide beat.
- Sits between an HWPE streamer (hci_core side) and the TCDM bank ports. It adds zero-byte-enable write skipping and a stall counter.

---
 rtl/hci_hwpe_wide_splitter.sv | 162 ++++++++++++++++
 tb/tb_hci_hwpe_wide_splitter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/hci_hwpe_wide_splitter.sv
// Wide HWPE request splitter onto word-interleaved TCDM banks with per-word grant
// tracking, zero-byte-enable write skipping, a read response buffer and a stall counter.
module hci_hwpe_wide_splitter #(
    parameter int unsigned NB_IN_CHAN  = 4,
    parameter int unsigned NB_OUT_CHAN = 8,
    parameter int unsigned WW          = 32,
    parameter int unsigned BW          = 8,
    parameter int unsigned AW          = 32,
    parameter int unsigned AWM         = 12
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    input  logic                          in_req,
    output logic                          in_gnt,
    input  logic                          in_wen,
    input  logic [AW-1:0]                 in_add,
    input  logic [NB_IN_CHAN*WW/BW-1:0]   in_be,
    input  logic [NB_IN_CHAN*WW-1:0]      in_data,
    output logic                          in_r_valid,
    output logic [NB_IN_CHAN*WW-1:0]      in_r_data,
    output logic [NB_OUT_CHAN-1:0]        out_req,
    input  logic [NB_OUT_CHAN-1:0]        out_gnt,
    output logic [NB_OUT_CHAN-1:0]        out_wen,
    output logic [NB_OUT_CHAN*AWM-1:0]    out_add,
    output logic [NB_OUT_CHAN*WW/BW-1:0]  out_be,
    output logic [NB_OUT_CHAN*WW-1:0]     out_data,
    input  logic [NB_OUT_CHAN*WW-1:0]     out_r_data,
    output logic [15:0]                   stall_cnt_o
);
    localparam int unsigned BPW   = WW / BW;
    localparam int unsigned LOG_N = $clog2(NB_OUT_CHAN);
    localparam int unsigned LOG_B = $clog2(BPW);
    localparam int unsigned LSB   = LOG_N + LOG_B;
    localparam int unsigned SUM_W = LOG_N + 1;
    localparam logic [AW-1:0] USED_MASK =
        ((AW'(1) << (LSB + AWM)) - AW'(1)) & ~((AW'(1) << LOG_B) - AW'(1));

    if (NB_IN_CHAN < 1 || NB_IN_CHAN > NB_OUT_CHAN) begin : g_bad_in_chan
        $error("NB_IN_CHAN must be in 1..NB_OUT_CHAN");
    end
    if (NB_OUT_CHAN < 2 || (NB_OUT_CHAN & (NB_OUT_CHAN - 1)) != 0) begin : g_bad_out_chan
        $error("NB_OUT_CHAN must be a power of 2");
    end
    if (LSB + AWM > AW) begin : g_bad_aw
        $error("LSB+AWM exceeds AW");
    end

    typedef logic [LOG_N-1:0] bank_t;

    logic [NB_IN_CHAN-1:0] done_q, done_d, pend_q, pend_d, skip, g, wrap;
    bank_t                 bank   [NB_IN_CHAN];
    bank_t                 bank_q [NB_IN_CHAN];
    bank_t                 bank_d [NB_IN_CHAN];
    logic [WW-1:0]         buf_q  [NB_IN_CHAN];
    logic [WW-1:0]         buf_d  [NB_IN_CHAN];
    logic [WW-1:0]         live   [NB_IN_CHAN];
    logic                  rvalid_q, rvalid_d;
    logic [15:0]           stall_q, stall_d;
    logic                  issue, all_done;
    bank_t                 off;
    logic [AWM-1:0]        row;
    logic                  unused_add;

    // Outputs are forced low during reset and flush, including the combinational ones.
    assign issue      = in_req & ~clear_i & rst_ni;
    assign off        = in_add[LSB-1:LOG_B];
    assign row        = in_add[LSB+AWM-1:LSB];
    assign unused_add = ^(in_add & ~USED_MASK);

    always_comb begin
        out_req  = '0;
        out_wen  = '0;
        out_add  = '0;
        out_be   = '0;
        out_data = '0;
        skip     = '0;
        g        = '0;
        wrap     = '0;
        for (int i = 0; i < NB_IN_CHAN; i++) begin
            {wrap[i], bank[i]} = {1'b0, off} + SUM_W'(i);
            skip[i] = ~in_wen & ~(|in_be[i*BPW +: BPW]);
            live[i] = out_r_data[int'(bank_q[i])*WW +: WW];
            if (issue) begin
                out_req[bank[i]]                    = ~done_q[i] & ~skip[i];
                out_wen[bank[i]]                    = in_wen;
                out_add[int'(bank[i])*AWM +: AWM]   = row + AWM'(wrap[i]);
                out_be[int'(bank[i])*BPW +: BPW]    = in_be[i*BPW +: BPW];
                out_data[int'(bank[i])*WW +: WW]    = in_data[i*WW +: WW];
                g[i] = ~done_q[i] & ~skip[i] & out_gnt[bank[i]];
            end
        end
        all_done = &(done_q | skip | g);
        in_gnt   = issue & all_done;
    end

    always_comb begin
        done_d   = done_q;
        pend_d   = g & ~skip;
        rvalid_d = in_gnt;
        stall_d  = stall_q;
        if (in_req & ~in_gnt && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
        if (in_req) begin
            done_d = in_gnt ? '0 : (done_q | g);
        end
        for (int i = 0; i < NB_IN_CHAN; i++) begin
            bank_d[i] = bank[i];
            // The buffer empties right after each beat is returned, so skipped words read 0.
            if (rvalid_q)       buf_d[i] = '0;
            else if (pend_q[i]) buf_d[i] = live[i];
            else                buf_d[i] = buf_q[i];
        end
        if (clear_i) begin
            done_d   = '0;
            pend_d   = '0;
            rvalid_d = 1'b0;
            stall_d  = '0;
            for (int i = 0; i < NB_IN_CHAN; i++) begin
                bank_d[i] = '0;
                buf_d[i]  = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_q   <= '0;
            pend_q   <= '0;
            rvalid_q <= 1'b0;
            stall_q  <= '0;
            for (int i = 0; i < NB_IN_CHAN; i++) begin
                bank_q[i] <= '0;
                buf_q[i]  <= '0;
            end
        end else begin
            done_q   <= done_d;
            pend_q   <= pend_d;
            rvalid_q <= rvalid_d;
            stall_q  <= stall_d;
            for (int i = 0; i < NB_IN_CHAN; i++) begin
                bank_q[i] <= bank_d[i];
                buf_q[i]  <= buf_d[i];
            end
        end
    end

    always_comb begin
        in_r_data = '0;
        for (int i = 0; i < NB_IN_CHAN; i++) begin
            if (!clear_i) in_r_data[i*WW +: WW] = pend_q[i] ? live[i] : buf_q[i];
        end
    end

    assign in_r_valid  = rvalid_q & ~clear_i;
    assign stall_cnt_o = stall_q;

    a_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (!in_req && !clear_i) |-> (done_q == '0));

endmodule

// File: tb/tb_hci_hwpe_wide_splitter.sv
// Directed bench for hci_hwpe_wide_splitter: each bank returns {tag, bank index}
// as read data, with the tag changed per step so capture timing is visible.
module tb_hci_hwpe_wide_splitter;
    logic          clk_i = 1'b0;
    logic          rst_ni, clear_i, in_req, in_wen;
    logic          in_gnt, in_r_valid;
    logic [31:0]   in_add;
    logic [15:0]   in_be;
    logic [127:0]  in_data, in_r_data;
    logic [7:0]    out_req, out_gnt, out_wen;
    logic [95:0]   out_add;
    logic [31:0]   out_be;
    logic [255:0]  out_data, out_r_data;
    logic [15:0]   stall_cnt_o;

    int checks = 0;
    int errors = 0;

    hci_hwpe_wide_splitter dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .in_req(in_req), .in_gnt(in_gnt), .in_wen(in_wen), .in_add(in_add),
        .in_be(in_be), .in_data(in_data), .in_r_valid(in_r_valid), .in_r_data(in_r_data),
        .out_req(out_req), .out_gnt(out_gnt), .out_wen(out_wen), .out_add(out_add),
        .out_be(out_be), .out_data(out_data), .out_r_data(out_r_data),
        .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_tag(input logic [15:0] t);
        for (int b = 0; b < 8; b++) out_r_data[b*32 +: 32] = {t, 16'(b)};
    endtask

    task automatic step();
        @(negedge clk_i);
    endtask

    initial begin
        rst_ni = 1'b0; clear_i = 1'b0; in_req = 1'b1; in_wen = 1'b1; in_add = '0;
        in_be = 16'hFFFF; in_data = '0; out_gnt = 8'hFF; set_tag(16'h0);
        #1;
        chk("rst_out_req", 128'(out_req), 128'h0);
        chk("rst_in_gnt", 128'(in_gnt), 128'h0);
        chk("rst_rvalid", 128'(in_r_valid), 128'h0);
        chk("rst_stall", 128'(stall_cnt_o), 128'h0);
        step(); in_req = 1'b0; out_gnt = '0;
        step(); rst_ni = 1'b1;

        // 1: aligned read, immediate grants
        step(); in_req = 1'b1; in_wen = 1'b1; in_add = 32'h0; out_gnt = 8'h0F; #1;
        chk("t1_out_req", 128'(out_req), 128'h0F);
        chk("t1_in_gnt", 128'(in_gnt), 128'h1);
        step(); in_req = 1'b0; out_gnt = '0; set_tag(16'h1); #1;
        chk("t1_rvalid", 128'(in_r_valid), 128'h1);
        chk("t1_rdata", in_r_data, 128'h00010003_00010002_00010001_00010000);
        chk("t1_stall", 128'(stall_cnt_o), 128'h0);

        // 2: wrap-around read, off=6
        step(); in_req = 1'b1; in_add = 32'h18; out_gnt = 8'hC3; #1;
        chk("t2_out_req", 128'(out_req), 128'hC3);
        chk("t2_out_add", 128'(out_add), 128'h001001);
        chk("t2_out_wen", 128'(out_wen), 128'hC3);
        chk("t2_in_gnt", 128'(in_gnt), 128'h1);
        step(); in_req = 1'b0; out_gnt = '0; set_tag(16'h2); #1;
        chk("t2_rdata", in_r_data, 128'h00020001_00020000_00020007_00020006);

        // 3: bank 2 withholds grant for 3 cycles
        step(); in_req = 1'b1; in_add = 32'h0; out_gnt = 8'h0B; #1;
        chk("t3_c0_out_req", 128'(out_req), 128'h0F);
        chk("t3_c0_in_gnt", 128'(in_gnt), 128'h0);
        step(); set_tag(16'h5); #1;
        chk("t3_c1_out_req", 128'(out_req), 128'h04);
        chk("t3_c1_in_gnt", 128'(in_gnt), 128'h0);
        step(); set_tag(16'h6); #1;
        chk("t3_c2_out_req", 128'(out_req), 128'h04);
        step(); out_gnt = 8'h04; #1;
        chk("t3_c3_in_gnt", 128'(in_gnt), 128'h1);
        chk("t3_c3_stall", 128'(stall_cnt_o), 128'h3);
        step(); in_req = 1'b0; out_gnt = '0; set_tag(16'h8); #1;
        chk("t3_rvalid", 128'(in_r_valid), 128'h1);
        chk("t3_rdata", in_r_data, 128'h00050003_00080002_00050001_00050000);
        chk("t3_stall", 128'(stall_cnt_o), 128'h3);

        // 4: sparse write, be=0x0F0F
        step(); in_req = 1'b1; in_wen = 1'b0; in_add = 32'h0; in_be = 16'h0F0F;
        in_data = 128'h33333333_22222222_11111111_00000000; out_gnt = 8'h01; #1;
        chk("t4_c0_out_req", 128'(out_req), 128'h05);
        chk("t4_c0_out_wen", 128'(out_wen), 128'h00);
        chk("t4_c0_out_be", 128'(out_be), 128'h00000F0F);
        chk("t4_c0_data_b2", 128'(out_data[64 +: 32]), 128'h22222222);
        chk("t4_c0_in_gnt", 128'(in_gnt), 128'h0);
        step(); out_gnt = 8'h04; set_tag(16'hA); #1;
        chk("t4_c1_out_req", 128'(out_req), 128'h04);
        chk("t4_c1_in_gnt", 128'(in_gnt), 128'h1);
        step(); in_req = 1'b0; in_wen = 1'b1; in_be = 16'hFFFF; out_gnt = '0; set_tag(16'hB); #1;
        chk("t4_rvalid", 128'(in_r_valid), 128'h1);
        chk("t4_rdata", in_r_data, 128'h00000000_000B0002_00000000_000A0000);
        chk("t4_stall", 128'(stall_cnt_o), 128'h4);

        // 5: back-to-back reads at 0x0 then 0x10
        step(); in_req = 1'b1; in_add = 32'h0; out_gnt = 8'hFF; #1;
        chk("t5_a_in_gnt", 128'(in_gnt), 128'h1);
        step(); in_add = 32'h10; set_tag(16'hD); #1;
        chk("t5_a_rvalid", 128'(in_r_valid), 128'h1);
        chk("t5_a_rdata", in_r_data, 128'h000D0003_000D0002_000D0001_000D0000);
        chk("t5_b_out_req", 128'(out_req), 128'hF0);
        chk("t5_b_in_gnt", 128'(in_gnt), 128'h1);
        step(); in_req = 1'b0; out_gnt = '0; set_tag(16'hE); #1;
        chk("t5_b_rvalid", 128'(in_r_valid), 128'h1);
        chk("t5_b_rdata", in_r_data, 128'h000E0007_000E0006_000E0005_000E0004);

        // 6: flush during a partial grant, then reset during a partial grant
        step(); in_req = 1'b1; in_add = 32'h0; out_gnt = 8'h03; #1;
        chk("t6_partial_gnt", 128'(in_gnt), 128'h0);
        step(); clear_i = 1'b1; out_gnt = '0; #1;
        chk("t6_clr_out_req", 128'(out_req), 128'h0);
        chk("t6_clr_rdata", in_r_data, 128'h0);
        step(); clear_i = 1'b0; out_gnt = 8'h0F; #1;
        chk("t6_stall_cleared", 128'(stall_cnt_o), 128'h0);
        chk("t6_done_cleared", 128'(out_req), 128'h0F);
        chk("t6_no_rvalid", 128'(in_r_valid), 128'h0);
        step(); in_req = 1'b0; out_gnt = '0; set_tag(16'h12); #1;
        chk("t6_rdata", in_r_data, 128'h00120003_00120002_00120001_00120000);
        step(); in_req = 1'b1; out_gnt = 8'h01; set_tag(16'h13);
        step(); out_gnt = 8'h0F; #1;
        chk("t6_pre_rst_stall", 128'(stall_cnt_o), 128'h1);
        rst_ni = 1'b0; #1;
        chk("t6_rst_out_req", 128'(out_req), 128'h0);
        chk("t6_rst_in_gnt", 128'(in_gnt), 128'h0);
        chk("t6_rst_stall", 128'(stall_cnt_o), 128'h0);
        chk("t6_rst_rdata", in_r_data, 128'h0);
        step(); in_req = 1'b0; out_gnt = '0;
        step(); rst_ni = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
